// File: rtl/led_mode_sequencer.sv
// Six-LED pattern sequencer: a divided step tick drives four display modes,
// and a debounced active-low push-button cycles through them.
module led_mode_sequencer #(
  parameter int unsigned DIV      = 4500000,
  parameter int unsigned DEBOUNCE = 270000
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       btn,
  output logic [5:0] leds,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {ROTATE, BOUNCE, BLINK, BINARY} mode_t;
  typedef enum logic {UP, DOWN} dir_t;

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE - 1);
  localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

  logic        sync1, sync2, btn_stable, stable_d, press;
  logic [19:0] db_cnt;
  logic [31:0] tick_cnt;
  logic        tick;
  mode_t       mode_q, mode_d;
  logic [2:0]  pos, pos_n;
  dir_t        dir, dir_n;
  logic [5:0]  bin, bin_n;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      btn_stable <= 1'b1;
      stable_d   <= 1'b1;
      db_cnt     <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= btn_stable;
      if (sync2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= sync2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  // Only the falling edge of the debounced level counts as a press.
  assign press = stable_d & ~btn_stable;
  assign tick  = (tick_cnt == DIV_LAST);

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) mode_q <= ROTATE;
    else              mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (press) begin
      case (mode_q)
        ROTATE:  mode_d = BOUNCE;
        BOUNCE:  mode_d = BLINK;
        BLINK:   mode_d = BINARY;
        default: mode_d = ROTATE;
      endcase
    end
  end

  always_comb begin
    pos_n = pos;
    dir_n = dir;
    if (pos > 3'd5) begin
      pos_n = '0;
      dir_n = UP;
    end else if (dir == UP) begin
      if (pos == 3'd5) begin
        pos_n = 3'd4;
        dir_n = DOWN;
      end else begin
        pos_n = pos + 3'd1;
      end
    end else begin
      if (pos == 3'd0) begin
        pos_n = 3'd1;
        dir_n = UP;
      end else begin
        pos_n = pos - 3'd1;
      end
    end
  end

  assign bin_n = bin + 6'd1;

  // A press overrides a coincident tick and restarts the step period.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tick_cnt <= '0;
      leds     <= 6'b111110;
      pos      <= '0;
      dir      <= UP;
      bin      <= '0;
    end else if (press) begin
      tick_cnt <= '0;
      case (mode_d)
        ROTATE: leds <= 6'b111110;
        BOUNCE: begin
          pos  <= '0;
          dir  <= UP;
          leds <= 6'b111110;
        end
        BLINK:  leds <= '1;
        default: begin
          bin  <= '0;
          leds <= '1;
        end
      endcase
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      if (tick) begin
        case (mode_q)
          ROTATE: leds <= {leds[4:0], leds[5]};
          BOUNCE: begin
            pos  <= pos_n;
            dir  <= dir_n;
            leds <= ~(6'b000001 << pos_n);
          end
          BLINK:  leds <= ~leds;
          default: begin
            bin  <= bin_n;
            leds <= ~bin_n;
          end
        endcase
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with DIV=4, DEBOUNCE=3.
module tb_led_mode_sequencer;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b1;
  logic       btn = 1'b1;
  logic [5:0] leds;
  logic [1:0] mode;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int press_cyc = 0;
  int press_lat = 6;

  localparam int BSEQ [10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};

  led_mode_sequencer #(.DIV(4), .DEBOUNCE(3)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .btn         (btn),
    .leds        (leds),
    .mode        (mode)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Expected LEDs e edges after the pattern (re)started with tick counter at 0.
  function automatic logic [5:0] exp_leds(input logic [1:0] m, input int e);
    int t;
    logic [5:0] one;
    t = e / 4;
    one = 6'b000001;
    case (m)
      2'd0:    return ~(one << (t % 6));
      2'd1:    return ~(one << BSEQ[t % 10]);
      2'd2:    return (t % 2 == 0) ? 6'b111111 : 6'b000000;
      default: return ~6'(t % 64);
    endcase
  endfunction

  task automatic press_btn(input logic [1:0] exp_mode);
    logic [1:0] m0;
    bit seen;
    int n;
    m0 = mode;
    seen = 0;
    n = 0;
    btn = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (mode !== m0) begin
        seen = 1;
        press_lat = n;
        press_cyc = cyc;
      end
    end
    nvec++;
    if (!seen || mode !== exp_mode) begin
      nerr++;
      $display("FAIL press_mode: got %0d expected %0d (seen=%0d)", mode, exp_mode, seen);
    end
    nvec++;
    if (leds !== exp_leds(exp_mode, 0)) begin
      nerr++;
      $display("FAIL press_init: got %b expected %b", leds, exp_leds(exp_mode, 0));
    end
    while (n < 6) begin
      step();
      n++;
    end
    btn = 1'b1;
    repeat (12) step();
    nvec++;
    if (mode !== exp_mode) begin
      nerr++;
      $display("FAIL single_press: got mode %0d expected %0d", mode, exp_mode);
    end
  endtask

  task automatic test_reset();
    #2 sys_reset_n = 1'b0;
    #1;
    nvec++;
    if (leds !== 6'b111110 || mode !== 2'd0) begin
      nerr++;
      $display("FAIL reset_async: leds %b mode %0d expected 111110 0", leds, mode);
    end
    step();
    step();
    nvec++;
    if (leds !== 6'b111110 || mode !== 2'd0) begin
      nerr++;
      $display("FAIL reset_hold: leds %b mode %0d expected 111110 0", leds, mode);
    end
  endtask

  task automatic test_rotate();
    int r;
    sys_reset_n = 1'b1;
    r = cyc;
    for (int k = 0; k < 30; k++) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd0, cyc - r) || mode !== 2'd0) begin
        nerr++;
        $display("FAIL rotate e=%0d: leds %b mode %0d expected %b 0", cyc - r, leds, mode,
                 exp_leds(2'd0, cyc - r));
      end
    end
  endtask

  task automatic test_press_bounce();
    press_btn(2'd1);
    while (cyc - press_cyc < 48) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd1, cyc - press_cyc)) begin
        nerr++;
        $display("FAIL bounce e=%0d: got %b expected %b", cyc - press_cyc, leds,
                 exp_leds(2'd1, cyc - press_cyc));
      end
    end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 8; g++) begin
      for (int s = 0; s < 5; s++) begin
        btn = (s < 2) ? 1'b0 : 1'b1;
        step();
        nvec++;
        if (mode !== 2'd1 || leds !== exp_leds(2'd1, cyc - press_cyc)) begin
          nerr++;
          $display("FAIL glitch e=%0d: leds %b mode %0d expected %b 1", cyc - press_cyc,
                   leds, mode, exp_leds(2'd1, cyc - press_cyc));
        end
      end
    end
    btn = 1'b1;
  endtask

  task automatic test_modes();
    press_btn(2'd2);
    repeat (20) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd2, cyc - press_cyc)) begin
        nerr++;
        $display("FAIL blink e=%0d: got %b expected %b", cyc - press_cyc, leds,
                 exp_leds(2'd2, cyc - press_cyc));
      end
    end
    press_btn(2'd3);
    while (cyc - press_cyc < 262) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd3, cyc - press_cyc)) begin
        nerr++;
        $display("FAIL binary e=%0d: got %b expected %b", cyc - press_cyc, leds,
                 exp_leds(2'd3, cyc - press_cyc));
      end
    end
    nvec++;
    if (leds !== 6'b111110) begin
      nerr++;
      $display("FAIL binary_65: got %b expected 111110", leds);
    end
    press_btn(2'd0);
    repeat (12) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd0, cyc - press_cyc)) begin
        nerr++;
        $display("FAIL rotate_again e=%0d: got %b expected %b", cyc - press_cyc, leds,
                 exp_leds(2'd0, cyc - press_cyc));
      end
    end
  endtask

  task automatic test_reset_mid();
    int r;
    press_btn(2'd1);
    while (cyc - press_cyc < 29) step();
    nvec++;
    if (leds !== 6'b110111) begin
      nerr++;
      $display("FAIL bounce_pos3: got %b expected 110111", leds);
    end
    #3 sys_reset_n = 1'b0;
    #1;
    nvec++;
    if (leds !== 6'b111110 || mode !== 2'd0) begin
      nerr++;
      $display("FAIL reset_mid: leds %b mode %0d expected 111110 0", leds, mode);
    end
    step();
    step();
    sys_reset_n = 1'b1;
    r = cyc;
    repeat (24) begin
      step();
      nvec++;
      if (leds !== exp_leds(2'd0, cyc - r) || mode !== 2'd0) begin
        nerr++;
        $display("FAIL reset_resume e=%0d: leds %b mode %0d expected %b 0", cyc - r, leds,
                 mode, exp_leds(2'd0, cyc - r));
      end
    end
  endtask

  task automatic test_aligned_press();
    int p, m, x, t;
    press_btn(2'd1);
    p = press_cyc;
    m = 1;
    while (p + 4 * m - press_lat <= cyc) m++;
    t = p + 4 * m;
    x = t - press_lat;
    while (cyc < x) step();
    btn = 1'b0;
    while (cyc < t - 1) step();
    nvec++;
    if (mode !== 2'd1 || leds !== exp_leds(2'd1, cyc - p)) begin
      nerr++;
      $display("FAIL aligned_before: leds %b mode %0d expected %b 1", leds, mode,
               exp_leds(2'd1, cyc - p));
    end
    step();
    nvec++;
    if (mode !== 2'd2 || leds !== 6'b111111) begin
      nerr++;
      $display("FAIL aligned_press: leds %b mode %0d expected 111111 2", leds, mode);
    end
    btn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      nvec++;
      if (leds !== ((k < 4) ? 6'b111111 : 6'b000000)) begin
        nerr++;
        $display("FAIL aligned_next k=%0d: got %b expected %b", k, leds,
                 (k < 4) ? 6'b111111 : 6'b000000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_press_bounce();
    test_glitch();
    test_modes();
    test_reset_mid();
    test_aligned_press();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller for the board's 6 active-low LEDs. It generates a periodic step tick and sequences the LED datapath through four display modes. A debounced push-button selects the mode. It sits between the raw button pin and the LED pins and replaces a fixed single-pattern blinker.

Parameters:
DIV, 4500000 (27000000 / 6), sys_clk cycles per pattern step; legal range 2..2^32-1
DEBOUNCE, 270000, sys_clk cycles btn must be stable before accepted (10 ms @ 27 MHz); legal range 2..2^20-1

Ports:
sys_clk  input  1  system clock (27 MHz)
sys_reset_n  input  1  asynchronous reset, active low
btn  input  1  raw push-button, active low, asynchronous to sys_clk
leds  output  6  LED drive, active low (0 = lit), registered
mode  output  2  current display mode, registered

Behaviour:
- Single clock domain sys_clk. sys_reset_n asserted (0) asynchronously clears all state. Release is synchronous to the next sys_clk edge and is used as-is.
- Reset values:
  - leds = 6'b111110
  - mode = 0
  - tick counter = 0
  - pos = 0
  - dir = up
  - bin = 0
  - sync flops = 1
  - btn_stable = 1
  - debounce counter = 0
- Button input path:
  - 2-FF synchronizer produces btn_s.
  - If btn_s == btn_stable: debounce counter <= 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE-1: btn_stable <= btn_s and the counter <= 0.
  - press = single-cycle pulse on the btn_stable 1->0 transition. Release generates no event.
- Tick generator:
  - 32-bit counter counts 0..DIV-1 and wraps.
  - tick is asserted in the cycle where counter == DIV-1.
  - First tick after reset release is on the DIV-th edge.
- Mode behaviour. Each tick updates leds and the per-mode state; leds change on that same edge (registered, no extra latency).
  - Mode 0 ROTATE: one LED lit. The lit position moves from index i to (i+1) mod 6; bit 5 wraps to bit 0.
  - Mode 1 BOUNCE:
    - One LED lit at pos (0..5) and dir.
    - pos steps by ±1. At pos 5 with dir up: dir <= down and pos <= 4. At pos 0 with dir down: dir <= up and pos <= 1.
    - Sequence: 0,1,2,3,4,5,4,3,2,1,0,1,...
  - Mode 2 BLINK: leds <= ~leds. Entry value is 6'b111111 (all off); the first tick lights all.
  - Mode 3 BINARY: bin <= bin + 1 (6-bit, wraps 63 -> 0). leds = ~bin.
- Press handling: on press, mode <= (mode+1) mod 4 (3 wraps to 0), tick counter <= 0, and pattern state re-initialises for the new mode:
  - ROTATE: leds = 6'b111110.
  - BOUNCE: pos = 0, dir = up, leds = 6'b111110.
  - BLINK: leds = 6'b111111.
  - BINARY: bin = 0, leds = 6'b111111.
- Press and tick in the same cycle: press wins and the tick is discarded. The next tick is DIV cycles later.
- Holding the button produces exactly one press. Glitches shorter than DEBOUNCE cycles are ignored.
- Reset asserted mid-pattern or mid-debounce: all state returns to reset values immediately, with no clock required.
- Unused combinations (pos 6,7) are unreachable. If reached, the next tick forces pos = 0 and dir = up.

Test Plan (DIV=4, DEBOUNCE=3 unless stated):
- Reset, btn=1, run 30 cycles -> leds 111110 until edge 4, then 111101, 111011, 110111, 101111, 011111, 111110 at 4-cycle spacing; mode stays 0.
- btn low 6 cycles, then high -> exactly one press; mode=1 and leds=111110. BOUNCE over 11 ticks yields lit index 0,1,2,3,4,5,4,3,2,1,0.
- btn pulses low 2 cycles, repeated every 5 cycles -> no press; mode unchanged; pattern timing undisturbed.
- Four clean presses -> mode goes 1,2,3,0. In mode 2 leds alternate 111111/000000 per tick. In mode 3 after 65 ticks, leds = ~6'd1 = 111110.
- Align the press pulse with counter==3 -> mode advances, leds take the new mode's initial value, and the next change occurs exactly 4 cycles later.
- Assert sys_reset_n between clock edges mid-BOUNCE at pos 3 -> leds=111110, mode=0, and counter=0 immediately; normal ROTATE resumes after release.
